// File: rtl/signed_sub_arbiter_pkg.sv
// Shared constants for the signed subtractor arbiter slice.
//   DEF_NREQ / DEF_W / DEF_LAT : default requester count, operand width, depth
//   res_width(w)               : width of an exact a-b result (one sign bit extra)
package signed_sub_pkg;

    localparam int DEF_NREQ = 4;
    localparam int DEF_W    = 4;
    localparam int DEF_LAT  = 3;

    function automatic int res_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/signed_sub_pipe.sv
// LAT-stage shift pipeline carrying valid/ID/result. Stage 1 performs the
// subtract; later stages just delay. Every stage moves only when en=1.
//   clk, rst_n              : clock, async active-low reset
//   en                      : shift enable (global advance)
//   in_vld, in_a, in_b, in_id : entry offered to stage 1
//   out_vld, out_data, out_id : last stage (the registered result)
//   busy                    : any stage holds a valid entry
module signed_sub_pipe
    import signed_sub_pkg::*;
#(
    parameter  int W   = DEF_W,
    parameter  int LAT = DEF_LAT,
    parameter  int IDW = 2,
    localparam int RW  = res_width(W)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           in_vld,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic [IDW-1:0] in_id,
    output logic           out_vld,
    output logic [RW-1:0]  out_data,
    output logic [IDW-1:0] out_id,
    output logic           busy
);

    logic [LAT:1]          vld_pipe;
    logic [LAT:1][RW-1:0]  data_pipe;
    logic [LAT:1][IDW-1:0] id_pipe;
    logic [RW-1:0]         diff;

    // Both operands zero-extended by one bit: the modular W+1 difference is
    // exactly the two's-complement signed result, no overflow possible.
    assign diff = {1'b0, in_a} - {1'b0, in_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
            id_pipe   <= '0;
        end else if (en) begin
            vld_pipe[1]  <= in_vld;
            data_pipe[1] <= diff;
            id_pipe[1]   <= in_id;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                data_pipe[s] <= data_pipe[s-1];
                id_pipe[s]   <= id_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LAT];
    assign out_data = data_pipe[LAT];
    assign out_id   = id_pipe[LAT];
    assign busy     = |vld_pipe;

endmodule

// File: rtl/signed_sub_arbiter.sv
// Round-robin share of one pipelined signed subtractor among NREQ requesters.
//   clk, rst_n            : clock, async active-low reset
//   req_vld_i / req_rdy_o : per-requester handshake (rdy one-hot or zero)
//   req_a_i / req_b_i     : packed unsigned operands, requester i at [i*W +: W]
//   res_vld_o / res_rdy_i : result handshake; whole pipe stalls on backpressure
//   res_data_o, res_id_o  : signed a-b (W+1 bits) and originating requester
//   idle_o                : no valid entry anywhere in the pipe
module signed_sub_arbiter
    import signed_sub_pkg::*;
#(
    parameter  int NREQ = DEF_NREQ,
    parameter  int W    = DEF_W,
    parameter  int LAT  = DEF_LAT,
    localparam int IDW  = $clog2(NREQ),
    localparam int RW   = res_width(W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_vld_i,
    output logic [NREQ-1:0]   req_rdy_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic              res_vld_o,
    input  logic              res_rdy_i,
    output logic [RW-1:0]     res_data_o,
    output logic [IDW-1:0]    res_id_o,
    output logic              idle_o
);

    logic           advance;
    logic           gnt_found;
    logic           xfer;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] rr_ptr;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic           busy;

    // (p + k) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    assign advance = !res_vld_o || res_rdy_i;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && req_vld_i[wrap_add(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // rst_n gating keeps the accept low while reset is held.
    assign xfer = rst_n && gnt_found && advance;

    always_comb begin
        req_rdy_o          = '0;
        req_rdy_o[gnt_idx] = xfer;
    end

    assign a_sel = req_a_i[gnt_idx*W +: W];
    assign b_sel = req_b_i[gnt_idx*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_ptr <= '0;
        else if (xfer) rr_ptr <= wrap_add(gnt_idx, 1);
    end

    signed_sub_pipe #(
        .W   (W),
        .LAT (LAT),
        .IDW (IDW)
    ) u_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .in_vld   (xfer),
        .in_a     (a_sel),
        .in_b     (b_sel),
        .in_id    (gnt_idx),
        .out_vld  (res_vld_o),
        .out_data (res_data_o),
        .out_id   (res_id_o),
        .busy     (busy)
    );

    assign idle_o = !busy;

endmodule

// File: tb/tb_signed_sub_arbiter.sv
module tb_signed_sub_arbiter;
    localparam int NREQ = 4, W = 4, LAT = 3, IDW = 2, RW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_vld_i = '0;
    logic [NREQ-1:0]   req_rdy_o;
    logic [NREQ*W-1:0] req_a_i = '0;
    logic [NREQ*W-1:0] req_b_i = '0;
    logic              res_vld_o;
    logic              res_rdy_i = 1'b0;
    logic [RW-1:0]     res_data_o;
    logic [IDW-1:0]    res_id_o;
    logic              idle_o;

    signed_sub_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
        .res_data_o(res_data_o), .res_id_o(res_id_o),
        .idle_o(idle_o)
    );

    always #5 clk = ~clk;

    // Reference model: issued items in order, each tagged with the number of
    // pipeline advances seen at issue; an item is at the output once LAT more
    // advances have happened.
    typedef struct {int id; int data; longint tag;} item_t;
    item_t           q[$];
    int              ptr_m;
    longint          adv_cnt;
    int              checks = 0, errors = 0;
    logic            exp_vld, exp_adv;
    logic [NREQ-1:0] exp_rdy;
    int              exp_g;

    function automatic void predict();
        exp_vld = (q.size() > 0) && (q[0].tag + LAT <= adv_cnt);
        exp_adv = !exp_vld || res_rdy_i;
        exp_rdy = '0;
        exp_g   = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr_m + k) % NREQ;
            if (exp_g < 0 && req_vld_i[i]) exp_g = i;
        end
        if (exp_g >= 0 && exp_adv) exp_rdy[exp_g] = 1'b1;
    endfunction

    task automatic step();
        if (exp_adv) begin
            if (exp_vld) void'(q.pop_front());
            if (exp_g >= 0) begin
                item_t it;
                it.id   = exp_g;
                it.data = int'(req_a_i[exp_g*W +: W]) - int'(req_b_i[exp_g*W +: W]);
                it.tag  = adv_cnt;
                q.push_back(it);
                ptr_m = (exp_g + 1) % NREQ;
            end
            adv_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        predict();
        step();
    endtask

    task automatic set_req(input int i, input bit v, input int a, input int b);
        req_vld_i[i]       = v;
        req_a_i[i*W +: W]  = W'(a);
        req_b_i[i*W +: W]  = W'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_vld_i = '0;
        res_rdy_i = 1'b0;
        q.delete();
        ptr_m = 0;
        adv_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (req_rdy_o !== 4'b0000) begin errors++; $display("FAIL reset_rdy got %b exp 0000", req_rdy_o); end
        checks++; if (res_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got %b exp 0", res_vld_o); end
        checks++; if (res_data_o !== 5'd0) begin errors++; $display("FAIL reset_data got %h exp 0", res_data_o); end
        checks++; if (res_id_o !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", res_id_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle_o); end
        do_reset();
        @(negedge clk);
        checks++; if (res_vld_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL post_reset vld=%b idle=%b exp 0/1", res_vld_o, idle_o); end
    endtask

    task automatic test_single();
        do_reset();
        res_rdy_i = 1'b1;
        set_req(0, 1, 9, 3);
        @(negedge clk);
        checks++; if (req_rdy_o !== 4'b0001) begin errors++; $display("FAIL single_rdy got %b exp 0001", req_rdy_o); end
        predict(); step();
        req_vld_i = '0;
        for (int c = 1; c < LAT; c++) begin
            @(negedge clk);
            checks++; if (res_vld_o !== 1'b0) begin errors++; $display("FAIL single_early cycle %0d vld=%b exp 0", c, res_vld_o); end
            predict(); step();
        end
        @(negedge clk);
        checks++; if (res_vld_o !== 1'b1 || res_data_o !== 5'd6 || res_id_o !== 2'd0)
            begin errors++; $display("FAIL single_result vld=%b data=%h id=%0d exp 1/06/0", res_vld_o, res_data_o, res_id_o); end
        predict(); step();
        repeat (3) cyc();
    endtask

    task automatic test_signs();
        do_reset();
        res_rdy_i = 1'b1;
        set_req(2, 1, 0, 15);
        cyc();
        set_req(2, 1, 15, 0);
        cyc();
        req_vld_i = '0;
        cyc();
        @(negedge clk);
        checks++; if (res_vld_o !== 1'b1 || res_data_o !== 5'b10001 || res_id_o !== 2'd2)
            begin errors++; $display("FAIL signs_neg vld=%b data=%b id=%0d exp 1/10001/2", res_vld_o, res_data_o, res_id_o); end
        predict(); step();
        @(negedge clk);
        checks++; if (res_vld_o !== 1'b1 || res_data_o !== 5'b01111 || res_id_o !== 2'd2)
            begin errors++; $display("FAIL signs_pos vld=%b data=%b id=%0d exp 1/01111/2", res_vld_o, res_data_o, res_id_o); end
        predict(); step();
        repeat (3) cyc();
    endtask

    task automatic test_round_robin();
        do_reset();
        res_rdy_i = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, $urandom_range(0, 15), $urandom_range(0, 15));
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            predict();
            checks++; if (req_rdy_o !== 4'(1 << (k % NREQ))) begin errors++; $display("FAIL rr_grant cycle %0d got %b exp %b", k, req_rdy_o, 4'(1 << (k % NREQ))); end
            if (k >= LAT) begin
                checks++; if (res_vld_o !== 1'b1 || res_id_o !== IDW'((k - LAT) % NREQ) || res_data_o !== RW'(q[0].data))
                    begin errors++; $display("FAIL rr_result cycle %0d vld=%b id=%0d data=%h exp 1/%0d/%h", k, res_vld_o, res_id_o, res_data_o, (k - LAT) % NREQ, RW'(q[0].data)); end
            end
            step();
            // granted requester presents a fresh pair, others hold
            set_req(exp_g, 1, $urandom_range(0, 15), $urandom_range(0, 15));
        end
    endtask

    task automatic test_stall();
        res_rdy_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            predict();
            checks++; if (req_rdy_o !== 4'b0000) begin errors++; $display("FAIL stall_rdy cycle %0d got %b exp 0000", c, req_rdy_o); end
            checks++; if (res_vld_o !== 1'b1 || res_data_o !== RW'(q[0].data) || res_id_o !== IDW'(q[0].id))
                begin errors++; $display("FAIL stall_hold cycle %0d vld=%b data=%h id=%0d exp 1/%h/%0d", c, res_vld_o, res_data_o, res_id_o, RW'(q[0].data), q[0].id); end
            step();
        end
        res_rdy_i = 1'b1;
        req_vld_i = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            predict();
            checks++; if (res_vld_o !== exp_vld || (exp_vld && (res_data_o !== RW'(q[0].data) || res_id_o !== IDW'(q[0].id))))
                begin errors++; $display("FAIL stall_release cycle %0d vld=%b data=%h id=%0d exp vld %b", c, res_vld_o, res_data_o, res_id_o, exp_vld); end
            checks++; if (idle_o !== (q.size() == 0)) begin errors++; $display("FAIL stall_idle cycle %0d got %b exp %b", c, idle_o, q.size() == 0); end
            step();
        end
    endtask

    task automatic test_rr_wrap();
        do_reset();
        res_rdy_i = 1'b1;
        set_req(0, 1, 1, 1);
        cyc();
        req_vld_i = '0;
        set_req(3, 1, 5, 2);
        @(negedge clk);
        checks++; if (req_rdy_o !== 4'b1000) begin errors++; $display("FAIL wrap_req3 got %b exp 1000", req_rdy_o); end
        predict(); step();
        set_req(3, 1, 7, 1);
        set_req(1, 1, 3, 4);
        @(negedge clk);
        checks++; if (req_rdy_o !== 4'b0010) begin errors++; $display("FAIL wrap_req1 got %b exp 0010", req_rdy_o); end
        predict(); step();
        req_vld_i = '0;
        repeat (5) cyc();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        res_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1, i + 4, i);
        repeat (3) begin
            @(negedge clk);
            predict();
            step();
            req_vld_i = req_vld_i & ~exp_rdy;
        end
        @(negedge clk);
        checks++; if (res_vld_o !== 1'b1) begin errors++; $display("FAIL midflight_pre vld=%b exp 1", res_vld_o); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (res_vld_o !== 1'b0) begin errors++; $display("FAIL midflight_vld got %b exp 0", res_vld_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL midflight_idle got %b exp 1", idle_o); end
        @(posedge clk);
        #2 rst_n = 1'b1;
        q.delete();
        ptr_m = 0;
        adv_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (res_vld_o !== 1'b0 || idle_o !== 1'b1) begin errors++; $display("FAIL midflight_stale cycle %0d vld=%b idle=%b exp 0/1", c, res_vld_o, idle_o); end
            predict(); step();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req_vld_i[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1, $urandom_range(0, 15), $urandom_range(0, 15));
            res_rdy_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            predict();
            checks++; if (req_rdy_o !== exp_rdy) begin errors++; $display("FAIL rand_rdy cycle %0d got %b exp %b", c, req_rdy_o, exp_rdy); end
            checks++; if (res_vld_o !== exp_vld) begin errors++; $display("FAIL rand_vld cycle %0d got %b exp %b", c, res_vld_o, exp_vld); end
            if (exp_vld) begin
                checks++; if (res_data_o !== RW'(q[0].data) || res_id_o !== IDW'(q[0].id))
                    begin errors++; $display("FAIL rand_result cycle %0d data=%h id=%0d exp %h/%0d", c, res_data_o, res_id_o, RW'(q[0].data), q[0].id); end
            end
            checks++; if (idle_o !== (q.size() == 0)) begin errors++; $display("FAIL rand_idle cycle %0d got %b exp %b", c, idle_o, q.size() == 0); end
            step();
            req_vld_i = req_vld_i & ~exp_rdy;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signs();
        test_round_robin();
        test_stall();
        test_rr_wrap();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
